// File: rtl/pipeline_data_mem_bytelane_pkg.sv
// Shared constants for the byte-lane MEM-stage data memory: access sizes and
// clear-sequencer state encoding.
package pipeline_data_mem_bytelane_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/pipeline_data_mem_bytelane_align.sv
// Lane steering for sub-word accesses: byte enables, replicated store data,
// extended load data and the alignment fault flag.
module pipeline_data_mem_bytelane_align
    import pipeline_data_mem_bytelane_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_word,
    output logic [31:0] ld_word,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = raw_word[{addr, 3'b000} +: 8];
    assign sel_half = addr[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        byte_en    = '0;
        st_word    = '0;
        ld_word    = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr;
                st_word = {4{st_data[7:0]}};
                ld_word = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                misaligned = addr[0];
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                st_word    = {2{st_data[15:0]}};
                ld_word    = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                misaligned = (addr != 2'b00);
                byte_en    = 4'b1111;
                st_word    = st_data;
                ld_word    = raw_word;
            end
            default: misaligned = 1'b1;
        endcase
        // A faulting access must neither write a lane nor return data.
        if (misaligned) begin
            byte_en = '0;
            ld_word = '0;
        end
    end

endmodule

// File: rtl/pipeline_data_mem_bytelane.sv
// MEM-stage data memory with byte lanes, optional registered read and a
// post-reset sequencer that zeroes every word before accesses are accepted.
module pipeline_data_mem_bytelane
    import pipeline_data_mem_bytelane_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_REG = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_MemWrite,
    input  logic        i_MemRead,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_misaligned,
    output logic        o_ready
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clear_we;

    logic [7:0]        mem_lane [0:3][0:DEPTH-1];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       raw_word;
    logic [3:0]        byte_en;
    logic [31:0]       st_word;
    logic [31:0]       ld_word;
    logic              misaligned;
    logic              store_en;
    logic [31:0]       load_data;
    logic              fault;
    logic              unused_addr_hi;

    assign word_idx       = i_address[ADDR_W+1:2];
    assign unused_addr_hi = ^i_address[31:ADDR_W+2];
    assign raw_word       = {mem_lane[3][word_idx], mem_lane[2][word_idx],
                             mem_lane[1][word_idx], mem_lane[0][word_idx]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clear_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we    = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CNT_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_ready = (state == ST_IDLE);

    pipeline_data_mem_bytelane_align u_align (
        .size        (i_size),
        .addr        (i_address[1:0]),
        .is_unsigned (i_unsigned),
        .st_data     (i_data),
        .raw_word    (raw_word),
        .byte_en     (byte_en),
        .st_word     (st_word),
        .ld_word     (ld_word),
        .misaligned  (misaligned)
    );

    assign store_en  = o_ready && i_MemWrite && !misaligned;
    assign load_data = (o_ready && i_MemRead && !misaligned) ? ld_word : 32'h0;
    assign fault     = o_ready && (i_MemRead || i_MemWrite) && misaligned;

    // The clear sequencer owns the write port until it finishes.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (clear_we) begin
                mem_lane[k][clr_cnt] <= 8'h00;
            end else if (store_en && byte_en[k]) begin
                mem_lane[k][word_idx] <= st_word[8*k +: 8];
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            logic [31:0] data_q;
            logic        mis_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    data_q <= '0;
                    mis_q  <= 1'b0;
                end else begin
                    data_q <= load_data;
                    mis_q  <= fault;
                end
            end

            assign o_data       = data_q;
            assign o_misaligned = mis_q;
        end else begin : g_comb_read
            assign o_data       = load_data;
            assign o_misaligned = fault;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_data_mem_bytelane.sv
// Drives a combinational-read and a registered-read instance in lockstep and
// checks both against a byte-array model of the memory.
module tb_pipeline_data_mem_bytelane;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NB     = DEPTH * 4;

    logic        i_clk;
    logic        i_rst;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] data0, data1;
    logic        mis0, mis1;
    logic        ready0, ready1;

    logic [7:0]  mdl [NB];
    int          tests;
    int          fails;

    pipeline_data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_REG(0)) u_comb (
        .i_clk(i_clk), .i_rst(i_rst), .i_MemWrite(mem_write), .i_MemRead(mem_read),
        .i_size(size), .i_unsigned(uns), .i_address(address), .i_data(wdata),
        .o_data(data0), .o_misaligned(mis0), .o_ready(ready0)
    );

    pipeline_data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_REG(1)) u_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_MemWrite(mem_write), .i_MemRead(mem_read),
        .i_size(size), .i_unsigned(uns), .i_address(address), .i_data(wdata),
        .o_data(data1), .o_misaligned(mis1), .o_ready(ready1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    task automatic model_eval(input logic wr, input logic rd, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, output logic [31:0] d, output logic m);
        int      n, ba;
        longint  value;
        logic    bad;
        n     = size_bytes(sz);
        ba    = int'(a % NB);
        bad   = (sz == 2'd3) || ((a % n) != 0);
        value = 0;
        if (!bad)
            for (int i = 0; i < n; i++) value = value + (longint'(mdl[ba + i]) << (8 * i));
        if (!bad && n < 4 && !u && value >= (longint'(1) << (8 * n - 1)))
            value = value + (longint'(1) << 32) - (longint'(1) << (8 * n));
        d = (rd && !bad) ? value[31:0] : 32'h0;
        m = (rd || wr) && bad;
    endtask

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n, ba;
        n  = size_bytes(sz);
        ba = int'(a % NB);
        for (int i = 0; i < n; i++) mdl[ba + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    // Called at a negedge; returns at the following negedge with inputs idle.
    task automatic access(input logic wr, input logic rd, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input string name,
                          input bit use_c = 1'b0, input logic [31:0] c_val = 32'h0);
        logic [31:0] exp_d;
        logic        exp_m;
        mem_write = wr; mem_read = rd; size = sz; uns = u; address = a; wdata = d;
        model_eval(wr, rd, sz, u, a, exp_d, exp_m);
        if (use_c) exp_d = c_val;
        #4;
        tests++;
        if (data0 !== exp_d) begin
            fails++; $display("FAIL %s comb data: got %h expected %h", name, data0, exp_d);
        end
        tests++;
        if (mis0 !== exp_m) begin
            fails++; $display("FAIL %s comb misaligned: got %b expected %b", name, mis0, exp_m);
        end
        @(posedge i_clk); #1;
        tests++;
        if (data1 !== exp_d) begin
            fails++; $display("FAIL %s reg data: got %h expected %h", name, data1, exp_d);
        end
        tests++;
        if (mis1 !== exp_m) begin
            fails++; $display("FAIL %s reg misaligned: got %b expected %b", name, mis1, exp_m);
        end
        if (wr && !exp_m) model_store(sz, a, d);
        @(negedge i_clk);
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    // Called at a negedge just after reset release; inputs are left as driven.
    task automatic wait_ready(input string name);
        int n0, n1, n;
        n0 = 0; n1 = 0; n = 0;
        while ((n0 == 0 || n1 == 0) && n < 4 * DEPTH) begin
            @(posedge i_clk); #1;
            n++;
            if (ready0 && n0 == 0) n0 = n;
            if (ready1 && n1 == 0) n1 = n;
        end
        tests++;
        if (n0 !== DEPTH) begin
            fails++; $display("FAIL %s comb clear length: got %0d expected %0d", name, n0, DEPTH);
        end
        tests++;
        if (n1 !== DEPTH) begin
            fails++; $display("FAIL %s reg clear length: got %0d expected %0d", name, n1, DEPTH);
        end
        tests++;
        if (data1 !== 32'h0 || mis1 !== 1'b0) begin
            fails++; $display("FAIL %s reg out after clear: got %h/%b expected 0/0", name, data1, mis1);
        end
        @(negedge i_clk);
        for (int i = 0; i < NB; i++) mdl[i] = 8'h00;
    endtask

    task automatic check_all_zero(input string name);
        for (int w = 0; w < DEPTH; w++)
            access(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, name, 1'b1, 32'h0);
    endtask

    task automatic test_reset();
        mem_read = 1'b1; mem_write = 1'b1; size = 2'd2; uns = 1'b0;
        address = 32'h0; wdata = 32'h12345678;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        tests++;
        if (data0 !== 32'h0 || mis0 !== 1'b0 || ready0 !== 1'b0) begin
            fails++; $display("FAIL reset comb outs: got %h/%b/%b expected 0/0/0", data0, mis0, ready0);
        end
        tests++;
        if (data1 !== 32'h0 || mis1 !== 1'b0 || ready1 !== 1'b0) begin
            fails++; $display("FAIL reset reg outs: got %h/%b/%b expected 0/0/0", data1, mis1, ready1);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        i_rst = 1'b0;
        wait_ready("reset");
        check_all_zero("clear_lw");
    endtask

    task automatic test_bytelanes();
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h8899AABB, "sw4");
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h4, 32'h0, "lb4",  1'b1, 32'hFFFFFFBB);
        access(1'b0, 1'b1, 2'd0, 1'b1, 32'h7, 32'h0, "lbu7", 1'b1, 32'h00000088);
        access(1'b0, 1'b1, 2'd1, 1'b0, 32'h6, 32'h0, "lh6",  1'b1, 32'hFFFF8899);
        access(1'b0, 1'b1, 2'd1, 1'b1, 32'h4, 32'h0, "lhu4", 1'b1, 32'h0000AABB);
        access(1'b0, 1'b1, 2'd2, 1'b1, 32'h4, 32'h0, "lw4_uns", 1'b1, 32'h8899AABB);
    endtask

    task automatic test_merge();
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h11223344, "sw8");
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h9, 32'hFFFFFFEE, "sb9");
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'hA, 32'h00005566, "shA");
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0, "lw8", 1'b1, 32'h5566EE44);
    endtask

    task automatic test_misaligned();
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, "sw0");
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h3, 32'h00001234, "sh3_fault", 1'b1, 32'h0);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h2, 32'h0, "lw2_fault", 1'b1, 32'h0);
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, "ill_st", 1'b1, 32'h0);
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0, "ill_ld", 1'b1, 32'h0);
        access(1'b1, 1'b1, 2'd1, 1'b0, 32'h1, 32'h0000BEEF, "sh1_both", 1'b1, 32'h0);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, "lw0_kept", 1'b1, 32'hCAFEF00D);
    endtask

    task automatic test_read_before_write();
        access(1'b1, 1'b1, 2'd2, 1'b0, 32'hC, 32'hDEADBEEF, "rbw_same", 1'b1, 32'h0);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'hC, 32'h0, "rbw_next", 1'b1, 32'hDEADBEEF);
        access(1'b0, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, "no_read", 1'b1, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_bytes(sz) - 1);
            op = $urandom_range(0, 3);
            access(op[1], op[0], sz, 1'($urandom_range(0, 1)), a, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_clear();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        mem_write = 1'b1; mem_read = 1'b1; size = 2'd2; uns = 1'b0;
        address = 32'h10; wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            tests++;
            if (data0 !== 32'h0 || data1 !== 32'h0 || ready0 !== 1'b0) begin
                fails++;
                $display("FAIL clear_outs cycle %0d: got %h/%h/%b expected 0/0/0", i, data0, data1, ready0);
            end
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_ready("mid_clear");
        mem_write = 1'b0; mem_read = 1'b0;
        check_all_zero("reclear_lw");
    endtask

    initial begin
        tests = 0; fails = 0;
        i_rst = 1'b1;
        mem_write = 1'b0; mem_read = 1'b0; size = 2'd0; uns = 1'b0;
        address = 32'h0; wdata = 32'h0;
        test_reset();
        test_bytelanes();
        test_merge();
        test_misaligned();
        test_read_before_write();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
